// File: rtl/complete_graph_flow_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : complete_graph_flow_sched_if
// Brief    : Requester/scheduler bundle for the complete-graph flow scheduler.
// Revision : 1.0
// ============================================================================
interface complete_graph_flow_sched_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req;
  logic [N*IW-1:0] req_dst;
  logic            abort;
  logic [N-1:0]    valve_open;
  logic            pump_en;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic [N-1:0]    ack;
  logic            err;

  modport master (
    output req, req_dst, abort,
    input  valve_open, pump_en, busy, grant_id, ack, err
  );

  modport slave (
    input  req, req_dst, abort,
    output valve_open, pump_en, busy, grant_id, ack, err
  );
endinterface
`default_nettype wire

// File: rtl/complete_graph_flow_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : complete_graph_flow_sched
// Brief    : Round-robin transfer scheduler sequencing port valves and pump.
// Revision : 1.0
// ============================================================================
module complete_graph_flow_sched #(
  parameter int N          = 8,
  parameter int SETTLE_CYC = 2,
  parameter int PUMP_CYC   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  complete_graph_flow_sched_if.slave     bus
);
  localparam int IW      = $clog2(N);
  localparam int C_MAXC  = (SETTLE_CYC > PUMP_CYC) ? SETTLE_CYC : PUMP_CYC;
  localparam int CW      = $clog2(C_MAXC + 1);
  localparam logic [CW-1:0] C_SET_LOAD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] C_PUMP_LOAD = CW'(PUMP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OPEN_DST  = 3'd1,
    S_OPEN_SRC  = 3'd2,
    S_PUMP      = 3'd3,
    S_CLOSE_SRC = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [IW-1:0] r_src, w_src_nx, r_dst, w_dst_nx, r_ptr, w_ptr_nx;
  logic [IW-1:0] r_grant, w_grant_nx;
  logic          r_errf, w_errf_nx;
  logic [N-1:0]  r_valve, w_valve_nx, r_ack, w_ack_nx;
  logic          r_pump, w_pump_nx, r_busy, w_busy_nx, r_err, w_err_nx;

  logic          w_found;
  logic [IW-1:0] w_pick, w_cand, w_pick_dst;

  // Round-robin search starting at the pointer, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
    w_pick_dst = bus.req_dst[w_pick*IW +: IW];
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_src_nx   = r_src;
    w_dst_nx   = r_dst;
    w_ptr_nx   = r_ptr;
    w_grant_nx = r_grant;
    w_errf_nx  = r_errf;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_src_nx   = w_pick;
          w_dst_nx   = w_pick_dst;
          w_grant_nx = w_pick;
          w_ptr_nx   = (w_pick == IW'(N - 1)) ? '0 : w_pick + IW'(1);
          if (w_pick_dst == w_pick || int'(w_pick_dst) >= N) begin
            w_errf_nx  = 1'b1;
            w_state_nx = S_DONE;
          end else begin
            w_errf_nx  = 1'b0;
            w_state_nx = S_OPEN_DST;
            w_cnt_nx   = C_SET_LOAD;
          end
        end
      end
      S_OPEN_DST: begin
        if (bus.abort) begin
          w_errf_nx  = 1'b1;
          w_state_nx = S_DONE;
        end else if (r_cnt == '0) begin
          w_state_nx = S_OPEN_SRC;
          w_cnt_nx   = C_SET_LOAD;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_OPEN_SRC, S_PUMP: begin
        if (bus.abort) begin
          w_errf_nx  = 1'b1;
          w_state_nx = S_CLOSE_SRC;
          w_cnt_nx   = C_SET_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nx = (r_state == S_OPEN_SRC) ? S_PUMP : S_CLOSE_SRC;
          w_cnt_nx   = (r_state == S_OPEN_SRC) ? C_PUMP_LOAD : C_SET_LOAD;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_CLOSE_SRC: begin
        if (r_cnt == '0) w_state_nx = S_DONE;
        else             w_cnt_nx   = r_cnt - CW'(1);
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_comb begin
    w_valve_nx = '0;
    w_pump_nx  = 1'b0;
    w_ack_nx   = '0;
    w_err_nx   = 1'b0;
    w_busy_nx  = (w_state_nx != S_IDLE);
    case (w_state_nx)
      S_OPEN_DST, S_CLOSE_SRC: w_valve_nx[w_dst_nx] = 1'b1;
      S_OPEN_SRC: begin
        w_valve_nx[w_dst_nx] = 1'b1;
        w_valve_nx[w_src_nx] = 1'b1;
      end
      S_PUMP: begin
        w_valve_nx[w_dst_nx] = 1'b1;
        w_valve_nx[w_src_nx] = 1'b1;
        w_pump_nx            = 1'b1;
      end
      S_DONE: begin
        w_ack_nx[w_src_nx] = 1'b1;
        w_err_nx           = w_errf_nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_errf  <= 1'b0;
      r_valve <= '0;
      r_pump  <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_src   <= w_src_nx;
      r_dst   <= w_dst_nx;
      r_ptr   <= w_ptr_nx;
      r_grant <= w_grant_nx;
      r_errf  <= w_errf_nx;
      r_valve <= w_valve_nx;
      r_pump  <= w_pump_nx;
      r_busy  <= w_busy_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
    end
  end

  assign bus.valve_open = r_valve;
  assign bus.pump_en    = r_pump;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_grant;
  assign bus.ack        = r_ack;
  assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_complete_graph_flow_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_complete_graph_flow_sched
// Brief    : Scoreboard bench for complete_graph_flow_sched (N=8, settle 2, pump 4).
// Revision : 1.0
// ============================================================================
module tb_complete_graph_flow_sched;
  localparam int N  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  complete_graph_flow_sched_if #(.N(N)) bus ();
  complete_graph_flow_sched #(.N(N), .SETTLE_CYC(2), .PUMP_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          src;
    int          dst;
    logic        err;
    int          len;
    logic [63:0] sig;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Per-cycle code: 0 nothing open, 1 dst only, 2 dst+src, 3 dst+src+pump, 4 other.
  function automatic logic [63:0] exp_sig(int n1, int n2, int n3, int n4);
    logic [63:0] s = '0;
    for (int i = 0; i < n1; i++) s = {s[59:0], 4'd1};
    for (int i = 0; i < n2; i++) s = {s[59:0], 4'd2};
    for (int i = 0; i < n3; i++) s = {s[59:0], 4'd3};
    for (int i = 0; i < n4; i++) s = {s[59:0], 4'd1};
    s = {s[59:0], 4'd0};
    return s;
  endfunction

  task automatic expect_xfer(int src, int dst, logic err, int n1, int n2, int n3, int n4);
    exp_t e;
    e.src = src; e.dst = dst; e.err = err;
    e.len = n1 + n2 + n3 + n4 + 1;
    e.sig = exp_sig(n1, n2, n3, n4);
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(int i, int d);
    bus.req[i]            = 1'b1;
    bus.req_dst[i*IW +: IW] = IW'(d);
  endtask

  // Waits for the acks in mask, dropping each req on its ack; optional abort pulse.
  task automatic run(logic [N-1:0] mask, int abort_at, int budget);
    logic [N-1:0] pend = mask;
    int bc = 0;
    int t  = 0;
    while (pend != '0 && t < budget) begin
      @(negedge clk);
      t++;
      if (bus.busy) bc++;
      bus.abort = (abort_at != 0) && bus.busy && (bc == abort_at);
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          bus.req[i] = 1'b0;
          pend[i]    = 1'b0;
        end
      end
    end
    bus.abort = 1'b0;
    if (pend != '0) begin
      errors++;
      checks++;
      $display("FAIL run_timeout: pending acks %0h expected 0", pend);
    end
  endtask

  // Monitor / scoreboard
  exp_t        m_e;
  logic [63:0] m_sig = '0;
  int          m_len = 0;
  logic [3:0]  m_code;
  logic [N-1:0] m_vs, m_vb;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("invariants",
          {61'd0, $countones(bus.valve_open) <= 2,
           (!bus.pump_en || $countones(bus.valve_open) == 2), $onehot0(bus.ack)},
          64'd7);
    end
    if (rst_n && bus.busy) begin
      m_len++;
      m_code = 4'd4;
      if (q.size() > 0) begin
        m_vs = N'(1) << q[0].dst;
        m_vb = m_vs | (N'(1) << q[0].src);
        if (bus.valve_open == '0 && !bus.pump_en)        m_code = 4'd0;
        else if (bus.valve_open == m_vs && !bus.pump_en) m_code = 4'd1;
        else if (bus.valve_open == m_vb && !bus.pump_en) m_code = 4'd2;
        else if (bus.valve_open == m_vb && bus.pump_en)  m_code = 4'd3;
      end
      m_sig = {m_sig[59:0], m_code};
    end
    if (rst_n && bus.ack != '0) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_ack: got %0h expected none", bus.ack);
      end else begin
        m_e = q.pop_front();
        chk("ack_vec",  64'(bus.ack), 64'(N'(1) << m_e.src));
        chk("grant_id", 64'(bus.grant_id), 64'(m_e.src));
        chk("err",      64'(bus.err), 64'(m_e.err));
        chk("length",   64'(m_len), 64'(m_e.len));
        chk("sequence", m_sig, m_e.sig);
      end
    end
    if (!rst_n || !bus.busy || bus.ack != '0) begin
      m_sig = '0;
      m_len = 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    bus.req     = '0;
    bus.req_dst = '0;
    bus.abort   = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valve", 64'(bus.valve_open), 64'd0);
    chk("rst_pump",  64'(bus.pump_en), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_ack",   64'(bus.ack), 64'd0);
    chk("rst_err",   64'(bus.err), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin from pointer 0, then a wrapped second round
    expect_xfer(1, 2, 1'b0, 2, 2, 4, 2);
    expect_xfer(5, 3, 1'b0, 2, 2, 4, 2);
    expect_xfer(7, 0, 1'b0, 2, 2, 4, 2);
    set_req(1, 2); set_req(5, 3); set_req(7, 0);
    run(8'hA2, 0, 200);
    expect_xfer(1, 4, 1'b0, 2, 2, 4, 2);
    expect_xfer(7, 1, 1'b0, 2, 2, 4, 2);
    set_req(1, 4); set_req(7, 1);
    run(8'h82, 0, 200);

    // Plain transfer 3 -> 6
    expect_xfer(3, 6, 1'b0, 2, 2, 4, 2);
    set_req(3, 6);
    run(8'h08, 0, 100);

    // Self-destination rejected
    expect_xfer(2, 2, 1'b1, 0, 0, 0, 0);
    set_req(2, 2);
    run(8'h04, 0, 100);

    // Abort in second pump cycle
    expect_xfer(0, 5, 1'b1, 2, 2, 2, 2);
    set_req(0, 5);
    run(8'h01, 6, 100);

    // Abort in first open-destination cycle
    expect_xfer(6, 1, 1'b1, 1, 0, 0, 0);
    set_req(6, 1);
    run(8'h40, 1, 100);

    // Reset during pump; pointer must restart at 0 so port 4 wins over 6
    set_req(4, 0);
    set_req(6, 2);
    bc = 0;
    for (int t = 0; t < 100 && bc < 6; t++) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    chk("pump_before_reset", 64'(bus.pump_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valve", 64'(bus.valve_open), 64'd0);
    chk("arst_pump",  64'(bus.pump_en), 64'd0);
    chk("arst_busy",  64'(bus.busy), 64'd0);
    chk("arst_grant", 64'(bus.grant_id), 64'd0);
    @(negedge clk);
    expect_xfer(4, 0, 1'b0, 2, 2, 4, 2);
    expect_xfer(6, 2, 1'b0, 2, 2, 4, 2);
    rst_n = 1'b1;
    run(8'h50, 0, 200);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
